imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the instruction-fetch requester (I-side) and the load/store requester (D-side) of the pipelined RISC-V core.
- Sits between the IF/MEM stages and the memory backend. Accepts one request at a time, forwards it to memory and returns a one-cycle response pulse to the winner.
- D-side has priority. A streak counter prevents I-side starvation.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- MAX_D_STREAK, 4, maximum consecutive D grants while I is pending before I is forced through (must be >=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_addr  in  ADDR_W  fetch byte address.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_resp_valid  out  1  fetch data valid (1-cycle pulse).
- i_resp_data  out  DATA_W  fetched instruction.
- d_req_valid  in  1  load/store request.
- d_req_write  in  1  1=store, 0=load.
- d_req_addr  in  ADDR_W  data byte address.
- d_req_wdata  in  DATA_W  store data.
- d_req_ready  out  1  data request accepted this cycle.
- d_resp_valid  out  1  load data / store ack (1-cycle pulse).
- d_resp_rdata  out  DATA_W  load data (0 for stores).
- mem_req  out  1  issue pulse to memory.
- mem_we  out  1  write enable, stable while busy.
- mem_addr  out  ADDR_W  byte address, stable while busy.
- mem_wdata  out  DATA_W  write data, stable while busy.
- mem_done  in  1  memory completed the access.
- mem_rdata  in  DATA_W  read data, valid with mem_done.

Behaviour:
- Reset values:
  - state=IDLE, d_streak=0.
  - All outputs 0: ready, resp_valid, resp data, mem_req, mem_we, mem_addr, mem_wdata.
- FSM states: IDLE, WAIT.
- IDLE:
  - Grant is combinational: d_req_ready / i_req_ready are high only in IDLE, for the winner only.
  - d_req_valid and NOT(i_req_valid and d_streak==MAX_D_STREAK) -> grant D.
  - Else if i_req_valid -> grant I.
  - Neither valid -> stay IDLE.
  - On grant: latch owner, we, addr, wdata. Next state WAIT. mem_req=1 (registered) in the first WAIT cycle only.
- Streak counter:
  - D grant with i_req_valid high: d_streak+1, saturating at MAX_D_STREAK.
  - Any I grant: d_streak=0.
  - D grant with I idle: d_streak=0.
- WAIT:
  - mem_req is 0 after the first cycle. mem_we/addr/wdata are held.
  - mem_done is ignored in the same cycle as mem_req. Minimum latency is 1 cycle after issue.
  - On mem_done: next cycle the owner's resp_valid=1 and resp data = registered mem_rdata (0 for a store); the other side's resp stays 0. Return to IDLE in that same cycle.
  - Request-to-response latency is therefore >= 3 cycles. There is one IDLE cycle between back-to-back grants.
- Requesters must hold valid/addr/wdata until ready. Dropping valid before ready is legal; nothing is issued.
- mem_done while IDLE: ignored, no response.
- Address handling:
  - Addresses pass through unmodified. The memory performs addr>>2.
  - Misalignment is not checked here.
- Reset mid-WAIT: aborts the transaction with no response pulse. A late mem_done after reset is ignored. The memory backend shares the same reset.
- resp data outputs are 0 whenever resp_valid is 0.

Decomposition:
- Shared package:
  - State enum {IDLE, WAIT}.
  - Owner enum {OWN_I, OWN_D}.
  - DATA_W/ADDR_W defaults.
- One natural sub-module: imem_dmem_prio_sel (combinational grant with streak compare plus the streak register).

Test Plan:
- Single fetch: i_req 0x0000_0010 with mem_done 2 cycles after mem_req and rdata 0x0000_0093 -> i_req_ready in cycle 0, mem_req in cycle 1, i_resp_valid with 0x0000_0093 in cycle 4; d_resp_valid stays 0.
- Simultaneous I (0x20) and D load (0x100) -> D granted first, I granted in the IDLE cycle after d_resp_valid.
- Starvation, MAX_D_STREAK=4: I held valid, D valid continuously -> grants D,D,D,D,I,D…; I waits at most 4 transactions.
- Store: d_req_write=1, addr 0x40, wdata 0xDEADBEEF -> mem_we=1, mem_wdata held through WAIT; ack pulse with d_resp_rdata=0.
- Reset asserted during WAIT, then mem_done arrives -> no resp_valid, all outputs 0, next request issues normally.
- Spurious mem_done in IDLE, and mem_done in the same cycle as mem_req -> both ignored; the response waits for a later mem_done.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
// Pure declarations, no logic and no latency.
// No flow control lives here; see imem_dmem_arbiter for the handshake.
package imem_dmem_arbiter_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_D_STREAK = 4;

  // IDLE: free to arbitrate. WAIT: one access outstanding at the memory.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Which requester owns the outstanding access.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/imem_dmem_prio_sel.sv
// D-priority grant select with a bounded D streak so fetch cannot starve.
// Grant is combinational (0 cycles); streak register updates on each grant.
// Grants only while arb_en is high; a loser simply keeps its valid asserted.
module imem_dmem_prio_sel
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK  // must be >= 1
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_vld,
  input  logic d_vld,
  output logic i_win,
  output logic d_win
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] d_streak;
  logic                force_i;

  // D wins unless fetch has been waiting through a full streak of D grants.
  always_comb begin
    force_i = i_vld && (d_streak == STREAK_MAX);
    d_win   = arb_en && d_vld && !force_i;
    i_win   = arb_en && i_vld && !(d_vld && !force_i);
  end

  // Count D grants taken while fetch was pending; any other grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_streak <= '0;
    end else if (d_win) begin
      if (!i_vld) begin
        d_streak <= '0;
      end else if (d_streak != STREAK_MAX) begin
        d_streak <= d_streak + STREAK_W'(1);
      end
    end else if (i_win) begin
      d_streak <= '0;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported variable-latency memory between fetch (I) and load/store (D).
// Request to response >= 3 cycles: grant, issue, >=1 memory cycle, then a 1-cycle response pulse.
// One access outstanding; ready is only offered in IDLE, to the winner, so losers hold their request.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state, state_nxt;
  owner_e owner;
  logic   arb_en;
  logic   i_win, d_win;
  logic   done_ok;

  // Arbitration is held off during reset so ready reads 0 while the core is reset.
  assign arb_en = (state == IDLE) && !reset;

  imem_dmem_prio_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_prio_sel (
    .clk   (clk),
    .reset (reset),
    .arb_en(arb_en),
    .i_vld (i_req_valid),
    .d_vld (d_req_valid),
    .i_win (i_win),
    .d_win (d_win)
  );

  assign i_req_ready = i_win;
  assign d_req_ready = d_win;

  // A done coincident with the issue pulse is too early to be ours and is dropped.
  assign done_ok = (state == WAIT) && !mem_req && mem_done;

  // Next state: grant moves to WAIT, an accepted done returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_win || d_win) state_nxt = WAIT;
      WAIT:    if (done_ok)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched command, issue pulse and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_I;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_valid <= 1'b0;
      d_resp_rdata <= '0;
    end else begin
      state        <= state_nxt;
      mem_req      <= i_win || d_win;
      i_resp_valid <= done_ok && (owner == OWN_I);
      d_resp_valid <= done_ok && (owner == OWN_D);
      i_resp_data  <= (done_ok && (owner == OWN_I)) ? mem_rdata : '0;
      d_resp_rdata <= (done_ok && (owner == OWN_D) && !mem_we) ? mem_rdata : '0;
      if (d_win) begin
        owner     <= OWN_D;
        mem_we    <= d_req_write;
        mem_addr  <= d_req_addr;
        mem_wdata <= d_req_wdata;
      end else if (i_win) begin
        owner     <= OWN_I;
        mem_we    <= 1'b0;
        mem_addr  <= i_req_addr;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench: behavioural memory, arbitration reference and response scoreboard.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Requesters hold valid until ready, and sometimes drop it early.
module tb_imem_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid;
  logic          d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_req_ready;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  // Expected response: side 1 = D, 0 = I.
  typedef struct packed {
    logic          side;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  byte           dut_log[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            i_resp_cyc = -1;
  logic [DW-1:0] bmem[64];   // backend memory contents
  logic [DW-1:0] rmem[64];   // reference view of memory

  // Requester drive state and knobs.
  logic          iv, dv, dw;
  logic [AW-1:0] ia, da;
  logic [DW-1:0] dwd;
  logic          i_rand, d_rand, i_renew, d_renew;
  logic          spur_en, force_done, reset_drv, rst_last, dut_in_reset;
  int            lat_fixed;

  // Reference model state.
  logic          ref_busy, grant_prev, issue_due, done_prev, resp_due;
  logic          i_hs, d_hs;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  int            d_run;      // D grants taken while I was waiting
  logic          be_busy;
  int            be_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_i();
    ia = $urandom;
  endtask

  task automatic new_d();
    da  = $urandom;
    dw  = 1'($urandom_range(0, 1));
    dwd = $urandom;
  endtask

  // Compare DUT outputs with the reference; record grants and expected responses.
  task automatic check_cycle();
    logic          free, gd, gi;
    logic [5:0]    idx;
    chk("mem_req_pulse", mem_req, issue_due);
    chk("resp_pulse_timing", i_resp_valid | d_resp_valid, resp_due);
    if (dut_in_reset) begin
      chk("reset_mem_we", mem_we, 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_mem_wdata", mem_wdata, 0);
    end else if (ref_busy) begin
      chk("held_mem_we", mem_we, cur_we);
      chk("held_mem_addr", mem_addr, cur_addr);
      if (cur_we) chk("held_mem_wdata", mem_wdata, cur_wdata);
    end
    free = !ref_busy && !reset_drv;
    gd   = free && dv && !(iv && d_run == MAXS);
    gi   = free && iv && !gd;
    chk("d_req_ready", d_req_ready, gd);
    chk("i_req_ready", i_req_ready, gi);
    if (gd) begin
      idx = da[7:2];
      if (dw) begin
        rmem[idx] = dwd;
        exp_q.push_back('{side: 1'b1, data: '0});
      end else begin
        exp_q.push_back('{side: 1'b1, data: rmem[idx]});
      end
      cur_we = dw; cur_addr = da; cur_wdata = dwd;
      d_run = iv ? ((d_run < MAXS) ? d_run + 1 : MAXS) : 0;
      d_hs = 1'b1; ref_busy = 1'b1; grant_prev = 1'b1;
    end
    if (gi) begin
      idx = ia[7:2];
      exp_q.push_back('{side: 1'b0, data: rmem[idx]});
      cur_we = 1'b0; cur_addr = ia; cur_wdata = '0;
      d_run = 0;
      i_hs = 1'b1; ref_busy = 1'b1; grant_prev = 1'b1;
    end
  endtask

  // One clock: update model timing, requesters and backend, then check.
  task automatic cycle();
    logic [5:0] idx;
    @(posedge clk);
    #1;
    cyc++;
    dut_in_reset = rst_last;
    if (dut_in_reset) begin
      ref_busy = 0; d_run = 0; grant_prev = 0; done_prev = 0; be_busy = 0;
      exp_q.delete();
    end
    rst_last  = reset_drv;
    issue_due = grant_prev; grant_prev = 0;
    resp_due  = done_prev;  done_prev  = 0;
    if (resp_due) ref_busy = 0;
    // requesters
    if (i_rand) begin
      if (i_hs || !iv) begin iv = ($urandom % 3) != 0; new_i(); end
      else if ($urandom % 16 == 0) iv = 1'b0;
    end else if (i_hs) begin
      if (i_renew) new_i(); else iv = 1'b0;
    end
    if (d_rand) begin
      if (d_hs || !dv) begin dv = ($urandom % 3) != 0; new_d(); end
      else if ($urandom % 16 == 0) dv = 1'b0;
    end else if (d_hs) begin
      if (d_renew) new_d(); else dv = 1'b0;
    end
    i_hs = 0; d_hs = 0;
    reset       = reset_drv;
    i_req_valid = iv; i_req_addr = ia;
    d_req_valid = dv; d_req_write = dw; d_req_addr = da; d_req_wdata = dwd;
    // backend memory
    mem_rdata = $urandom;
    mem_done  = 1'b0;
    if (mem_req) begin
      be_busy  = 1'b1;
      be_cnt   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      mem_done = spur_en && ($urandom % 2 == 0);
    end else if (be_busy) begin
      be_cnt--;
      if (be_cnt == 0) begin
        be_busy = 0; mem_done = 1'b1; done_prev = 1'b1;
        idx = mem_addr[7:2];
        if (mem_we) bmem[idx] = mem_wdata;
        else        mem_rdata = bmem[idx];
      end
    end else begin
      mem_done = force_done || (spur_en && ($urandom % 4 == 0));
    end
    @(negedge clk);
    check_cycle();
  endtask

  // Scoreboard monitor: pops an expectation whenever a response pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_req_ready) dut_log.push_back("I");
      if (d_req_ready) dut_log.push_back("D");
      if (i_resp_valid) i_resp_cyc = cyc;
      if (!i_resp_valid) chk("i_resp_data_idle", i_resp_data, 0);
      if (!d_resp_valid) chk("d_resp_rdata_idle", d_resp_rdata, 0);
      if (i_resp_valid || d_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {i_resp_valid, d_resp_valid}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("resp_side", {i_resp_valid, d_resp_valid}, e.side ? 2'b01 : 2'b10);
          chk("resp_data", e.side ? d_resp_rdata : i_resp_data, e.data);
        end
      end
    end
  end

  initial begin
    byte exp_seq[6];
    int  c0;
    reset = 1'b1; reset_drv = 1'b1; rst_last = 1'b1; dut_in_reset = 1'b1;
    iv = 0; ia = '0; dv = 0; dw = 0; da = '0; dwd = '0;
    i_rand = 0; d_rand = 0; i_renew = 0; d_renew = 0;
    spur_en = 0; force_done = 0; lat_fixed = 2;
    ref_busy = 0; grant_prev = 0; issue_due = 0; done_prev = 0; resp_due = 0;
    i_hs = 0; d_hs = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
    d_run = 0; be_busy = 0; be_cnt = 0;
    i_req_valid = 0; i_req_addr = '0; d_req_valid = 0; d_req_write = 0;
    d_req_addr = '0; d_req_wdata = '0; mem_done = 0; mem_rdata = '0;
    for (int k = 0; k < 64; k++) begin
      bmem[k] = 32'(k) * 32'h0101_0101 ^ 32'h5A00_0000;
      rmem[k] = bmem[k];
    end

    // reset state
    repeat (3) cycle();
    reset_drv = 0;
    cycle();

    // single fetch, memory done 2 cycles after issue
    bmem[4] = 32'h0000_0093; rmem[4] = 32'h0000_0093;
    iv = 1; ia = 32'h0000_0010;
    c0 = cyc + 1;
    repeat (7) cycle();
    chk("fetch_latency", 64'(i_resp_cyc - c0), 4);

    // simultaneous I and D load: D first, then I
    dut_log.delete();
    iv = 1; ia = 32'h20; dv = 1; dw = 0; da = 32'h100;
    repeat (10) cycle();
    chk("simul_count", dut_log.size(), 2);
    chk("simul_first", (dut_log.size() > 0) ? dut_log[0] : 8'h0, "D");
    chk("simul_second", (dut_log.size() > 1) ? dut_log[1] : 8'h0, "I");

    // store then read back
    dv = 1; dw = 1; da = 32'h40; dwd = 32'hDEAD_BEEF; lat_fixed = 3;
    repeat (7) cycle();
    chk("store_in_memory", bmem[16], 32'hDEAD_BEEF);
    dv = 1; dw = 0; da = 32'h40;
    repeat (7) cycle();

    // starvation bound: both sides continuously valid
    lat_fixed = 1; dut_log.delete();
    i_renew = 1; d_renew = 1; iv = 1; new_i(); dv = 1; new_d();
    repeat (40) cycle();
    exp_seq = '{"D", "D", "D", "D", "I", "D"};
    chk("starve_len", dut_log.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("starve_grant_%0d", k), (k < dut_log.size()) ? dut_log[k] : 8'h0, exp_seq[k]);
    i_renew = 0; d_renew = 0; iv = 0; dv = 0;
    repeat (8) cycle();

    // spurious done in IDLE and alongside the issue pulse
    spur_en = 1; lat_fixed = 3; iv = 1; ia = 32'h0000_0088;
    repeat (12) cycle();
    spur_en = 0;

    // reset mid-WAIT, then a late done
    lat_fixed = 6; iv = 1; ia = 32'h80;
    repeat (2) cycle();
    iv = 0; reset_drv = 1;
    cycle();
    reset_drv = 0; force_done = 1;
    cycle();
    force_done = 0;
    repeat (4) cycle();
    lat_fixed = 2; iv = 1; ia = 32'h84;
    repeat (7) cycle();

    // randomized traffic
    lat_fixed = 0; spur_en = 1; i_rand = 1; d_rand = 1;
    repeat (3000) cycle();
    i_rand = 0; d_rand = 0; iv = 0; dv = 0; spur_en = 0;
    repeat (12) cycle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
